// File: rtl/y86_mem_arbiter_pkg.sv
// Shared encodings for the y86 data-memory arbiter: FSM states and access owners.
package y86_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Width of the latency and starvation counters; both limits are at most 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/y86_mem_lat_timer.sv
// Loadable down-counter with a zero flag; it times the fixed memory access window.
module y86_mem_lat_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // A load takes priority over a decrement, and the count parks at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares the single data-memory port between the pipeline (P) and the debug loader (D),
// one fixed-latency access at a time, with bounded starvation of D.
module y86_mem_arbiter
  import y86_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m_rd_i,
  input  logic          m_wr_i,
  input  logic [AW-1:0] m_addr_i,
  input  logic [DW-1:0] m_wdata_i,
  output logic          m_stall_o,
  output logic          m_done_o,
  output logic [DW-1:0] m_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          gnt_dbg_o,
  output logic          err_o
);

  state_e           state_q;
  owner_e           owner_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             we_q;
  logic             mem_we_q;
  logic             m_done_q;
  logic             d_ack_q;
  logic [DW-1:0]    m_rdata_q;
  logic [DW-1:0]    d_rdata_q;
  logic [CNT_W-1:0] starve_q;
  logic             err_q;

  logic p_req;
  logic starve_hit;
  logic grant_p;
  logic grant_d;
  logic lat_zero;

  assign p_req      = m_rd_i | m_wr_i;
  assign starve_hit = d_req_i && (starve_q == CNT_W'(STARVE_LIM));
  assign grant_p    = (state_q == S_IDLE) && p_req && !starve_hit;
  assign grant_d    = (state_q == S_IDLE) && d_req_i && !grant_p;

  y86_mem_lat_timer #(
    .W(CNT_W)
  ) u_lat_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (grant_p | grant_d),
    .load_val_i (CNT_W'(LAT - 1)),
    .dec_i      (state_q == S_ACCESS),
    .zero_o     (lat_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_P;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_we_q  <= 1'b0;
      m_done_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      m_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      m_done_q <= 1'b0;
      d_ack_q  <= 1'b0;

      if (m_rd_i && m_wr_i) begin
        err_q <= 1'b1;
      end

      // D's patience only accumulates while it keeps asking and P keeps winning.
      if (!d_req_i || grant_d) begin
        starve_q <= '0;
      end else if (grant_p && (starve_q != CNT_W'(STARVE_LIM))) begin
        starve_q <= starve_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (grant_p) begin
            addr_q   <= m_addr_i;
            wdata_q  <= m_wdata_i;
            we_q     <= m_wr_i;
            mem_we_q <= m_wr_i;
            owner_q  <= OWN_P;
            state_q  <= S_ACCESS;
          end else if (grant_d) begin
            addr_q   <= d_addr_i;
            wdata_q  <= d_wdata_i;
            we_q     <= d_we_i;
            mem_we_q <= d_we_i;
            owner_q  <= OWN_D;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_zero) begin
            if (!we_q && (owner_q == OWN_D)) begin
              d_rdata_q <= mem_rdata_i;
            end else if (!we_q) begin
              m_rdata_q <= mem_rdata_i;
            end
            m_done_q <= (owner_q == OWN_P);
            d_ack_q  <= (owner_q == OWN_D);
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is gated by reset so that every output reads zero while reset is held.
  assign m_stall_o   = rst_ni & p_req & ~m_done_q;
  assign m_done_o    = m_done_q;
  assign m_rdata_o   = m_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = mem_we_q;
  assign gnt_dbg_o   = (owner_q == OWN_D);
  assign err_o       = err_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter: a LAT=1 instance and a LAT=3/STARVE_LIM=2 instance on shared inputs.
module tb_y86_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        preload;
  logic        m_rd, m_wr, d_req, d_we;
  logic [31:0] m_addr, m_wdata, d_addr, d_wdata;

  logic        m_stall1, m_done1, d_ack1, mem_we1, gnt1, err1;
  logic [31:0] m_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        m_stall3, m_done3, d_ack3, mem_we3, gnt3, err3;
  logic [31:0] m_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  int checkCount = 0;
  int passCount  = 0;

  y86_mem_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_LIM(4)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_rd_i(m_rd), .m_wr_i(m_wr), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_stall_o(m_stall1), .m_done_o(m_done1), .m_rdata_o(m_rdata1),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack1), .d_rdata_o(d_rdata1),
    .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_we_o(mem_we1),
    .mem_rdata_i(mem_rdata1), .gnt_dbg_o(gnt1), .err_o(err1)
  );

  y86_mem_arbiter #(.AW(32), .DW(32), .LAT(3), .STARVE_LIM(2)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_rd_i(m_rd), .m_wr_i(m_wr), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_stall_o(m_stall3), .m_done_o(m_done3), .m_rdata_o(m_rdata3),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack3), .d_rdata_o(d_rdata3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_we_o(mem_we3),
    .mem_rdata_i(mem_rdata3), .gnt_dbg_o(gnt3), .err_o(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory models with combinational read; preload seeds known words.
  assign mem_rdata1 = mem1[mem_addr1[9:2]];
  assign mem_rdata3 = mem3[mem_addr3[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 32'h0;
        mem3[i] <= 32'h0;
      end
      mem1[64] <= 32'hDEADBEEF;
      mem3[64] <= 32'hCAFEF00D;
    end else begin
      if (mem_we1) mem1[mem_addr1[9:2]] <= mem_wdata1;
      if (mem_we3) mem3[mem_addr3[9:2]] <= mem_wdata3;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    m_rd = 1'b0; m_wr = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset;
    m_rd = 1'b1;
    #1;
    checkCount++; if (m_stall1 !== 1'b0) $display("[TB] FAIL reset_stall1: got %b want 0", m_stall1); else passCount++;
    checkCount++; if (m_done1 !== 1'b0) $display("[TB] FAIL reset_done1: got %b want 0", m_done1); else passCount++;
    checkCount++; if (d_ack3 !== 1'b0) $display("[TB] FAIL reset_ack3: got %b want 0", d_ack3); else passCount++;
    checkCount++; if (mem_we3 !== 1'b0) $display("[TB] FAIL reset_we3: got %b want 0", mem_we3); else passCount++;
    checkCount++; if (mem_addr3 !== 32'h0) $display("[TB] FAIL reset_addr3: got %h want 0", mem_addr3); else passCount++;
    checkCount++; if ({gnt1, err1, gnt3, err3} !== 4'h0) $display("[TB] FAIL reset_gnt_err: got %b want 0000", {gnt1, err1, gnt3, err3}); else passCount++;
    checkCount++; if ({m_rdata1, d_rdata1} !== 64'h0) $display("[TB] FAIL reset_rdata1: got %h want 0", {m_rdata1, d_rdata1}); else passCount++;
    m_rd = 1'b0;
  endtask

  task automatic test_p_read_lat1;
    m_rd = 1'b1; m_addr = 32'h100;
    #1;
    checkCount++; if (m_stall1 !== 1'b1) $display("[TB] FAIL lat1_stall_t0: got %b want 1", m_stall1); else passCount++;
    tick();
    checkCount++; if (m_stall1 !== 1'b1) $display("[TB] FAIL lat1_stall_t1: got %b want 1", m_stall1); else passCount++;
    checkCount++; if (m_done1 !== 1'b0) $display("[TB] FAIL lat1_done_t1: got %b want 0", m_done1); else passCount++;
    checkCount++; if (mem_addr1 !== 32'h100) $display("[TB] FAIL lat1_addr_t1: got %h want 100", mem_addr1); else passCount++;
    checkCount++; if (mem_we1 !== 1'b0) $display("[TB] FAIL lat1_we_t1: got %b want 0", mem_we1); else passCount++;
    tick();
    checkCount++; if (m_done1 !== 1'b1) $display("[TB] FAIL lat1_done_t2: got %b want 1", m_done1); else passCount++;
    checkCount++; if (m_rdata1 !== 32'hDEADBEEF) $display("[TB] FAIL lat1_rdata: got %h want deadbeef", m_rdata1); else passCount++;
    checkCount++; if (m_stall1 !== 1'b0) $display("[TB] FAIL lat1_stall_t2: got %b want 0", m_stall1); else passCount++;
    m_rd = 1'b0;
    drain();
  endtask

  task automatic test_p_write_lat3;
    int weCount = 0, weCycle = -1, doneCount = 0, doneCycle = -1;
    logic [31:0] weAddr = 32'h0, weData = 32'h0;
    m_wr = 1'b1; m_addr = 32'h20; m_wdata = 32'h12345678;
    #1;
    checkCount++; if (m_stall3 !== 1'b1) $display("[TB] FAIL wr3_stall_t0: got %b want 1", m_stall3); else passCount++;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mem_we3) begin weCount++; weCycle = i; weAddr = mem_addr3; weData = mem_wdata3; end
      if (m_done3) begin doneCount++; doneCycle = i; m_wr = 1'b0; end
    end
    checkCount++; if (weCount !== 1) $display("[TB] FAIL wr3_we_count: got %0d want 1", weCount); else passCount++;
    checkCount++; if (weCycle !== 1) $display("[TB] FAIL wr3_we_cycle: got %0d want 1", weCycle); else passCount++;
    checkCount++; if ({weAddr, weData} !== {32'h20, 32'h12345678}) $display("[TB] FAIL wr3_we_addr_data: got %h want 0000002012345678", {weAddr, weData}); else passCount++;
    checkCount++; if (doneCount !== 1) $display("[TB] FAIL wr3_done_count: got %0d want 1", doneCount); else passCount++;
    checkCount++; if (doneCycle !== 4) $display("[TB] FAIL wr3_done_cycle: got %0d want 4", doneCycle); else passCount++;
    checkCount++; if (m_rdata3 !== 32'hCAFEF00D) $display("[TB] FAIL wr3_rdata_kept: got %h want cafef00d", m_rdata3); else passCount++;
    drain();
    checkCount++; if (mem3[8] !== 32'h12345678) $display("[TB] FAIL wr3_mem: got %h want 12345678", mem3[8]); else passCount++;
  endtask

  task automatic test_err;
    int doneCycle = -1;
    m_rd = 1'b1; m_wr = 1'b1; m_addr = 32'h40; m_wdata = 32'hA5A55A5A;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (m_done3 && doneCycle < 0) begin doneCycle = i; m_rd = 1'b0; m_wr = 1'b0; end
    end
    checkCount++; if (doneCycle !== 4) $display("[TB] FAIL err_done_cycle: got %0d want 4", doneCycle); else passCount++;
    checkCount++; if ({err1, err3} !== 2'b11) $display("[TB] FAIL err_set: got %b want 11", {err1, err3}); else passCount++;
    drain();
    checkCount++; if (mem3[16] !== 32'hA5A55A5A) $display("[TB] FAIL err_write_done: got %h want a5a55a5a", mem3[16]); else passCount++;
    doneCycle = -1;
    m_rd = 1'b1; m_addr = 32'h100;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (m_done3 && doneCycle < 0) begin
        doneCycle = i; m_rd = 1'b0;
        checkCount++; if (m_rdata3 !== 32'hCAFEF00D) $display("[TB] FAIL err_clean_rdata: got %h want cafef00d", m_rdata3); else passCount++;
      end
    end
    checkCount++; if (doneCycle !== 4) $display("[TB] FAIL err_clean_cycle: got %0d want 4", doneCycle); else passCount++;
    drain();
    checkCount++; if (err3 !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", err3); else passCount++;
  endtask

  task automatic test_starve;
    int ackCycle = -1, doneBefore = 0;
    m_rd = 1'b1; m_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (ackCycle < 0 && m_done3) doneBefore++;
      if (ackCycle < 0 && d_ack3) begin
        ackCycle = i;
        checkCount++; if (d_rdata3 !== 32'h12345678) $display("[TB] FAIL starve_d_rdata: got %h want 12345678", d_rdata3); else passCount++;
        checkCount++; if (gnt3 !== 1'b1) $display("[TB] FAIL starve_gnt: got %b want 1", gnt3); else passCount++;
        checkCount++; if (m_stall3 !== 1'b1) $display("[TB] FAIL starve_p_stalled: got %b want 1", m_stall3); else passCount++;
        checkCount++; if (u_lat3.starve_q !== 4'd0) $display("[TB] FAIL starve_cnt_clear: got %0d want 0", u_lat3.starve_q); else passCount++;
        d_req = 1'b0;
      end
    end
    checkCount++; if (ackCycle !== 14) $display("[TB] FAIL starve_ack_cycle: got %0d want 14", ackCycle); else passCount++;
    checkCount++; if (doneBefore !== 2) $display("[TB] FAIL starve_p_wins: got %0d want 2", doneBefore); else passCount++;
    drain();
  endtask

  task automatic test_d_pulse;
    int ack1 = 0, ack3 = 0, we3 = 0;
    m_rd = 1'b1; m_addr = 32'h100;
    for (int i = 1; i <= 10; i++) begin
      tick();
      d_req = (i == 1); d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hBAD0BAD0;
      if (d_ack1) ack1++;
      if (d_ack3) ack3++;
      if (mem_we3) we3++;
      if (m_done3) m_rd = 1'b0;
    end
    checkCount++; if ({ack1, ack3} !== {32'd0, 32'd0}) $display("[TB] FAIL dpulse_no_ack: got %0d,%0d want 0,0", ack1, ack3); else passCount++;
    checkCount++; if (we3 !== 0) $display("[TB] FAIL dpulse_no_write: got %0d want 0", we3); else passCount++;
    checkCount++; if (gnt3 !== 1'b0) $display("[TB] FAIL dpulse_gnt: got %b want 0", gnt3); else passCount++;
    drain();
    checkCount++; if (mem3[16] !== 32'hA5A55A5A) $display("[TB] FAIL dpulse_mem_intact: got %h want a5a55a5a", mem3[16]); else passCount++;
  endtask

  task automatic test_reset_mid;
    int doneCycle = -1, ack3 = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    tick();
    tick();
    checkCount++; if (gnt3 !== 1'b1) $display("[TB] FAIL rmid_gnt_before: got %b want 1", gnt3); else passCount++;
    rst_n = 1'b0;
    #1;
    checkCount++; if ({d_ack3, gnt3, mem_we3, err3} !== 4'h0) $display("[TB] FAIL rmid_flags: got %b want 0000", {d_ack3, gnt3, mem_we3, err3}); else passCount++;
    checkCount++; if (mem_addr3 !== 32'h0) $display("[TB] FAIL rmid_addr: got %h want 0", mem_addr3); else passCount++;
    checkCount++; if (d_rdata3 !== 32'h0) $display("[TB] FAIL rmid_d_rdata: got %h want 0", d_rdata3); else passCount++;
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_ack3) ack3++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_ack3) ack3++;
    end
    checkCount++; if (ack3 !== 0) $display("[TB] FAIL rmid_no_ack: got %0d want 0", ack3); else passCount++;
    m_rd = 1'b1; m_addr = 32'h100;
    #1;
    checkCount++; if (m_stall3 !== 1'b1) $display("[TB] FAIL rmid_stall: got %b want 1", m_stall3); else passCount++;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (m_done3 && doneCycle < 0) begin
        doneCycle = i; m_rd = 1'b0;
        checkCount++; if (m_rdata3 !== 32'hCAFEF00D) $display("[TB] FAIL rmid_rdata: got %h want cafef00d", m_rdata3); else passCount++;
      end
    end
    checkCount++; if (doneCycle !== 4) $display("[TB] FAIL rmid_done_cycle: got %0d want 4", doneCycle); else passCount++;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    m_rd = 1'b0; m_wr = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    tick();
    tick();
    test_reset();
    preload = 1'b0;
    rst_n = 1'b1;
    tick();
    test_p_read_lat1();
    test_p_write_lat3();
    test_err();
    test_starve();
    test_d_pulse();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Sequences and shares the single data-memory port (y86_datamem) between two requesters: the pipeline memory stage (port P) and a debug/program-loader port (port D).
- Latches one request at a time, drives the memory for a fixed LAT-cycle access, and returns read data with a one-cycle completion pulse.
- Stalls the pipeline while a P access is outstanding.
- Bounds D starvation with a saturating wait counter.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 1, memory access cycles from address issue to valid mem_rdata (legal 1..15)
- STARVE_LIM, 4, consecutive lost arbitration cycles after which D wins over P (legal 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m_rd  in  1  P read request (level, held while m_stall)
- m_wr  in  1  P write request (level, held while m_stall)
- m_addr  in  AW  P address
- m_wdata  in  DW  P write data
- m_stall  out  1  freeze pipeline: P request pending and not completing this cycle
- m_done  out  1  one-cycle pulse, P access complete
- m_rdata  out  DW  P read data, valid during m_done
- d_req  in  1  D request (level, held until d_ack)
- d_we  in  1  D write when 1, read when 0
- d_addr  in  AW  D address
- d_wdata  in  DW  D write data
- d_ack  out  1  one-cycle pulse, D access complete
- d_rdata  out  DW  D read data, valid during d_ack
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  DW  from data memory
- gnt_dbg  out  1  current or last access owned by D
- err  out  1  sticky: m_rd and m_wr asserted together

Behaviour:
- Reset (async, active-low): state=IDLE; lat_cnt, starve_cnt and all data registers are 0; every output is 0, including mem_we, which drops immediately. Memory content of a write in flight when reset asserts is undefined.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, P selection:
  - Grant P if (m_rd|m_wr) and not (d_req and starve_cnt==STARVE_LIM).
  - Grant D otherwise, if d_req.
  - On a grant: latch addr, wdata, we and owner; set lat_cnt=LAT-1; go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata driven from the latched values for all LAT cycles.
  - mem_we=1 only in the first ACCESS cycle, and only if the latched we=1.
  - When lat_cnt==0: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged) and go to RESP. Otherwise decrement lat_cnt.
- RESP:
  - Pulse m_done or d_ack for exactly one cycle, then go to IDLE.
  - The next grant is evaluated in that IDLE cycle, so there is no back-to-back grant in RESP.
- Latency: request seen in IDLE at cycle t; done/ack is high in cycle t+LAT+1; throughput is one access per LAT+2 cycles.
- m_stall = (m_rd|m_wr) & ~m_done, combinational. With no P request, m_stall=0.
- starve_cnt:
  - Increments (saturating at STARVE_LIM) on each IDLE cycle where d_req=1 and P is granted.
  - Cleared when D is granted or when d_req=0.
- Simultaneous m_rd and m_wr: treated as a write; err set and held until reset.
- D drops d_req before grant: nothing issued.
- D drops d_req after grant: access completes and d_ack still pulses.
- P drops its request mid-access (flush): access completes (a write is never cancelled); m_done still pulses and is ignored upstream.
- mem_addr and mem_wdata hold their last values in IDLE and RESP; mem_we=0 outside the first ACCESS cycle.
- gnt_dbg is updated on grant and holds until the next grant.

Decomposition:
- Shared include alongside y86_define.v:
  - state encodings S_IDLE, S_ACCESS, S_RESP
  - owner encodings OWN_P, OWN_D
- One natural sub-module: y86_mem_lat_timer, a loadable down-counter with a zero flag, reused for the LAT countdown.
- The starvation counter stays inline.

Test Plan:
- LAT=1, P read m_rd=1 m_addr=0x100 with mem returning 0xDEADBEEF -> m_stall=1 for cycles t, t+1; m_done and m_rdata=0xDEADBEEF at t+2; m_stall=0 at t+2.
- LAT=3, P write m_wr=1 m_addr=0x20 m_wdata=0x12345678 -> mem_we high exactly one cycle (t+1) with matching addr/data; m_done at t+4; m_rdata unchanged.
- STARVE_LIM=2, P requesting continuously and d_req=1 from t -> P wins twice; D granted on third arbitration; d_ack pulses; starve_cnt back to 0.
- m_rd=m_wr=1 at 0x40 -> write performed, err=1 and stays 1 after further clean accesses.
- Async reset (reset=0) asserted mid-ACCESS of a D read -> all outputs 0 immediately, no d_ack; after release, a new P read completes normally in LAT+2 cycles.
- d_req pulsed for one cycle while P access in progress, dropped before IDLE -> no D access issued, no d_ack.
